// File: rtl/jk_ctr_pkg.sv
// Shared definitions for the JK-based counter blocks.
//   state_t  : controller state (IDLE = parked, RUN = counting down)
//   JK_*     : {j,k} input encodings for a single JK flip-flop cell
package jk_ctr_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   localparam logic [1:0] JK_HOLD   = 2'b00;
   localparam logic [1:0] JK_RESET  = 2'b01;
   localparam logic [1:0] JK_SET    = 2'b10;
   localparam logic [1:0] JK_TOGGLE = 2'b11;

endpackage

// File: rtl/jk_ff_rn.sv
// Single JK flip-flop with asynchronous active-low clear.
// Ports:
//   i_clk   : rising-edge clock
//   i_rst_n : asynchronous active-low reset, clears o_q to 0
//   i_j     : J input
//   i_k     : K input
//   o_q     : stored bit
module jk_ff_rn
   import jk_ctr_pkg::*;
(
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_j,
   input  logic i_k,
   output logic o_q
);

   logic r_q;

   // Classic JK behaviour: hold, clear, set or toggle on each rising edge.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_q <= 1'b0;
      end else begin
         case ({i_j, i_k})
            JK_HOLD:   r_q <= r_q;
            JK_RESET:  r_q <= 1'b0;
            JK_SET:    r_q <= 1'b1;
            JK_TOGGLE: r_q <= ~r_q;
            default:   r_q <= r_q;
         endcase
      end
   end

   assign o_q = r_q;

endmodule

// File: rtl/jk_down_ctr.sv
// Loadable down-counter/timer built from JK flip-flop cells.
// Loads a start value, decrements on enabled clocks while running, pulses
// o_tc for one cycle at terminal count, then either parks at zero
// (one-shot) or reloads the captured start value (periodic divide-by-N).
// Ports:
//   i_clk         : rising-edge clock
//   i_rst_n       : asynchronous active-low reset
//   i_load        : parallel load strobe (wins over counting)
//   i_din         : load value, also captured as the reload value
//   i_en          : count enable while running
//   i_reload_mode : 1 = auto-reload at terminal count, 0 = one-shot
//   o_q           : current count
//   o_tc          : registered terminal-count pulse
//   o_busy        : high while running
module jk_down_ctr
   import jk_ctr_pkg::*;
#(
   parameter int WIDTH = 4
)
(
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_load,
   input  logic [WIDTH-1:0] i_din,
   input  logic             i_en,
   input  logic             i_reload_mode,
   output logic [WIDTH-1:0] o_q,
   output logic             o_tc,
   output logic             o_busy
);

   state_t           r_state;
   state_t           w_nextState;
   logic             r_tc;
   logic             w_tcNext;
   logic [WIDTH-1:0] r_reload;
   logic [WIDTH-1:0] w_q;
   logic [WIDTH-1:0] w_j;
   logic [WIDTH-1:0] w_k;
   logic [WIDTH-1:0] w_borrow;
   logic             w_terminal;

   assign w_terminal = (w_q == WIDTH'(1));

   // Borrow chain: a bit flips on decrement only when every lower bit is 0.
   always_comb begin
      logic v_chain;
      v_chain = 1'b1;
      for (int i = 0; i < WIDTH; i++) begin
         w_borrow[i] = v_chain;
         v_chain     = v_chain & ~w_q[i];
      end
   end

   // J/K steering and next-state logic. Load beats counting; a load of 0
   // parks the block in IDLE. Terminal count either parallel-loads the
   // reload value or clears the cells, so zero is never decremented.
   always_comb begin
      w_j         = '0;
      w_k         = '0;
      w_nextState = r_state;
      w_tcNext    = 1'b0;
      if (i_load) begin
         w_j         = i_din;
         w_k         = ~i_din;
         w_nextState = (i_din != '0) ? RUN : IDLE;
      end else if ((r_state == RUN) && i_en) begin
         if (w_terminal) begin
            w_tcNext = 1'b1;
            if (i_reload_mode) begin
               w_j = r_reload;
               w_k = ~r_reload;
            end else begin
               w_j         = '0;
               w_k         = '1;
               w_nextState = IDLE;
            end
         end else begin
            w_j = w_borrow;
            w_k = w_borrow;
         end
      end
   end

   // Controller state and the one-cycle terminal-count pulse.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= IDLE;
         r_tc    <= 1'b0;
      end else begin
         r_state <= w_nextState;
         r_tc    <= w_tcNext;
      end
   end

   // Reload value is whatever was last loaded.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_reload <= '0;
      end else if (i_load) begin
         r_reload <= i_din;
      end
   end

   // One JK cell per counter bit.
   generate
      for (genvar g = 0; g < WIDTH; g++) begin : g_bit
         jk_ff_rn u_cell (
            .i_clk   (i_clk),
            .i_rst_n (i_rst_n),
            .i_j     (w_j[g]),
            .i_k     (w_k[g]),
            .o_q     (w_q[g])
         );
      end
   endgenerate

   assign o_q    = w_q;
   assign o_tc   = r_tc;
   assign o_busy = (r_state == RUN);

endmodule

// File: tb/tb_jk_down_ctr.sv
// Directed self-checking bench for jk_down_ctr.
// Two instances share clock and reset: a 4-bit counter for the main
// sequences and an 8-bit counter for the full-range countdown.
module tb_jk_down_ctr;

   logic       clock = 1'b0;
   logic       rstN;
   logic       load4, en4, mode4;
   logic [3:0] din4;
   logic [3:0] q4;
   logic       tc4, busy4;
   logic       load8, en8, mode8;
   logic [7:0] din8;
   logic [7:0] q8;
   logic       tc8, busy8;

   typedef struct {
      string      tag;
      int         unit;
      logic [7:0] q;
      logic       tc;
      logic       busy;
   } expect_t;

   expect_t scoreboard[$];
   int      checks = 0;
   int      errors = 0;

   always #5 clock = ~clock;

   jk_down_ctr #(.WIDTH(4)) dut4 (
      .i_clk         (clock),
      .i_rst_n       (rstN),
      .i_load        (load4),
      .i_din         (din4),
      .i_en          (en4),
      .i_reload_mode (mode4),
      .o_q           (q4),
      .o_tc          (tc4),
      .o_busy        (busy4)
   );

   jk_down_ctr #(.WIDTH(8)) dut8 (
      .i_clk         (clock),
      .i_rst_n       (rstN),
      .i_load        (load8),
      .i_din         (din8),
      .i_en          (en8),
      .i_reload_mode (mode8),
      .o_q           (q8),
      .o_tc          (tc8),
      .o_busy        (busy8)
   );

   task automatic pushExpect(input string tag, input int unit, input logic [7:0] q,
                             input logic tc, input logic busy);
      expect_t e;
      e.tag  = tag;
      e.unit = unit;
      e.q    = q;
      e.tc   = tc;
      e.busy = busy;
      scoreboard.push_back(e);
   endtask

   task automatic checkOutput();
      expect_t    e;
      logic [7:0] obsQ;
      logic       obsTc;
      logic       obsBusy;
      checks++;
      assert (scoreboard.size() > 0) else begin
         errors++;
         $error("[TB] FAIL scoreboardEmpty observed size 0 expected >0");
         return;
      end
      e = scoreboard.pop_front();
      if (e.unit == 8) begin
         obsQ    = q8;
         obsTc   = tc8;
         obsBusy = busy8;
      end else begin
         obsQ    = {4'b0000, q4};
         obsTc   = tc4;
         obsBusy = busy4;
      end
      checks++;
      assert (obsQ === e.q) else begin
         errors++;
         $error("[TB] FAIL %s.q observed %0h expected %0h", e.tag, obsQ, e.q);
      end
      checks++;
      assert (obsTc === e.tc) else begin
         errors++;
         $error("[TB] FAIL %s.tc observed %0b expected %0b", e.tag, obsTc, e.tc);
      end
      checks++;
      assert (obsBusy === e.busy) else begin
         errors++;
         $error("[TB] FAIL %s.busy observed %0b expected %0b", e.tag, obsBusy, e.busy);
      end
   endtask

   // Drive the 4-bit instance for one edge and check it just after.
   task automatic applyStimulus(input logic ld, input logic [3:0] d, input logic en,
                                input logic mode, input logic [3:0] expQ,
                                input logic expTc, input logic expBusy, input string tag);
      @(negedge clock);
      load4 = ld;
      din4  = d;
      en4   = en;
      mode4 = mode;
      pushExpect(tag, 4, {4'b0000, expQ}, expTc, expBusy);
      @(posedge clock);
      #1;
      checkOutput();
   endtask

   // Same for the 8-bit instance.
   task automatic applyStimulus8(input logic ld, input logic [7:0] d, input logic en,
                                 input logic mode, input logic [7:0] expQ,
                                 input logic expTc, input logic expBusy, input string tag);
      @(negedge clock);
      load8 = ld;
      din8  = d;
      en8   = en;
      mode8 = mode;
      pushExpect(tag, 8, expQ, expTc, expBusy);
      @(posedge clock);
      #1;
      checkOutput();
   endtask

   // Guard against a hung run.
   initial begin
      #100000;
      $display("[TB] FAIL watchdog observed timeout expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      rstN  = 1'b1;
      load4 = 1'b0; din4 = '0; en4 = 1'b0; mode4 = 1'b0;
      load8 = 1'b0; din8 = '0; en8 = 1'b0; mode8 = 1'b0;
      #1 rstN = 1'b0;
      @(posedge clock);
      #1;
      pushExpect("reset4", 4, 8'h00, 1'b0, 1'b0);
      checkOutput();
      pushExpect("reset8", 8, 8'h00, 1'b0, 1'b0);
      checkOutput();
      @(negedge clock);
      rstN = 1'b1;

      // Asynchronous reset between edges
      applyStimulus(1, 4'd5, 0, 0, 4'd5, 0, 1, "preReset");
      #2 rstN = 1'b0;
      #1;
      pushExpect("asyncReset", 4, 8'h00, 1'b0, 1'b0);
      checkOutput();
      @(negedge clock);
      rstN = 1'b1;

      // One-shot from 5 (en at the load edge is ignored)
      applyStimulus(1, 4'd5, 1, 0, 4'd5, 0, 1, "oneShotLoad");
      applyStimulus(0, 4'd0, 1, 0, 4'd4, 0, 1, "oneShot4");
      applyStimulus(0, 4'd0, 1, 0, 4'd3, 0, 1, "oneShot3");
      applyStimulus(0, 4'd0, 1, 0, 4'd2, 0, 1, "oneShot2");
      applyStimulus(0, 4'd0, 1, 0, 4'd1, 0, 1, "oneShot1");
      applyStimulus(0, 4'd0, 1, 0, 4'd0, 1, 0, "oneShotTc");
      applyStimulus(0, 4'd0, 1, 0, 4'd0, 0, 0, "oneShotHold");
      applyStimulus(0, 4'd0, 1, 0, 4'd0, 0, 0, "oneShotNoWrap");

      // Auto-reload period 3
      applyStimulus(1, 4'd3, 1, 1, 4'd3, 0, 1, "reloadLoad");
      applyStimulus(0, 4'd0, 1, 1, 4'd2, 0, 1, "reload2a");
      applyStimulus(0, 4'd0, 1, 1, 4'd1, 0, 1, "reload1a");
      applyStimulus(0, 4'd0, 1, 1, 4'd3, 1, 1, "reloadTcA");
      applyStimulus(0, 4'd0, 1, 1, 4'd2, 0, 1, "reload2b");
      applyStimulus(0, 4'd0, 1, 1, 4'd1, 0, 1, "reload1b");
      applyStimulus(0, 4'd0, 1, 1, 4'd3, 1, 1, "reloadTcB");

      // Enable gating
      applyStimulus(1, 4'd4, 0, 0, 4'd4, 0, 1, "gateLoad");
      applyStimulus(0, 4'd0, 1, 0, 4'd3, 0, 1, "gateEn1");
      applyStimulus(0, 4'd0, 0, 0, 4'd3, 0, 1, "gateEn0a");
      applyStimulus(0, 4'd0, 0, 0, 4'd3, 0, 1, "gateEn0b");
      applyStimulus(0, 4'd0, 1, 0, 4'd2, 0, 1, "gateEn1b");

      // Boundaries: load zero, reload mid-count, load on terminal edge
      applyStimulus(1, 4'd0, 1, 0, 4'd0, 0, 0, "loadZero");
      applyStimulus(0, 4'd0, 1, 0, 4'd0, 0, 0, "zeroIdle");
      applyStimulus(1, 4'd3, 0, 0, 4'd3, 0, 1, "midLoad3");
      applyStimulus(0, 4'd0, 1, 0, 4'd2, 0, 1, "midCount2");
      applyStimulus(1, 4'd9, 1, 0, 4'd9, 0, 1, "midLoad9");
      applyStimulus(0, 4'd0, 1, 0, 4'd8, 0, 1, "midCount8");
      applyStimulus(1, 4'd1, 0, 0, 4'd1, 0, 1, "termLoad1");
      applyStimulus(1, 4'd6, 1, 0, 4'd6, 0, 1, "loadAtTerminal");
      applyStimulus(0, 4'd0, 1, 0, 4'd5, 0, 1, "afterTermLoad");

      // reload_mode only matters on the terminal edge
      applyStimulus(1, 4'd1, 0, 1, 4'd1, 0, 1, "modeLoad1");
      applyStimulus(0, 4'd0, 1, 1, 4'd1, 1, 1, "modeReload");
      applyStimulus(0, 4'd0, 0, 1, 4'd1, 0, 1, "modePause");
      applyStimulus(0, 4'd0, 1, 0, 4'd0, 1, 0, "modeOneShot");
      applyStimulus(0, 4'd0, 1, 0, 4'd0, 0, 0, "modeIdle");

      // Full-range countdown on the 8-bit instance
      applyStimulus8(1, 8'hFF, 1, 0, 8'hFF, 0, 1, "w8Load");
      for (int i = 1; i <= 255; i++) begin
         applyStimulus8(0, 8'h00, 1, 0, 8'(255 - i), (i == 255), (i != 255), "w8Count");
      end
      applyStimulus8(0, 8'h00, 1, 0, 8'h00, 0, 0, "w8NoWrap");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/jk_down_ctr.md
# jk_down_ctr

Loadable synchronous down-counter/timer built from JK flip-flop cells, the counting-down complement to the existing JK up-counter. Software or a controller loads a start value; the block decrements on enabled clocks, flags the terminal count with a one-cycle pulse, and either stops at zero (one-shot) or reloads automatically (periodic divide-by-N). It is intended as the countdown/timeout companion to the up-counter in the same lab datapath.

## Interface
- WIDTH, 4: counter width in bits (2..16).
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- load  in  1  parallel load strobe, sampled at the rising edge.
- din  in  WIDTH  load value; also captured as the reload value.
- en  in  1  count enable; qualifies decrement in RUN.
- reload_mode  in  1  1 = auto-reload at terminal count, 0 = one-shot.
- q  out  WIDTH  current count.
- tc  out  1  registered terminal-count pulse, exactly one cycle.
- busy  out  1  1 while in RUN.

## Operation
- States: IDLE, RUN. busy = (state == RUN).
- Reset (rst_n low, any time): q = 0, reload register = 0, tc = 0, state = IDLE, busy = 0. Release is clean; first action needs load.
- Priority at each edge: reset > load > count > hold.
- load = 1: q <= din, reload <= din, tc <= 0; state <= RUN if din != 0, else IDLE. Load mid-count restarts; en ignored that edge.
- RUN, en = 1, q > 1: q <= q - 1, tc <= 0.
- RUN, en = 1, q == 1 (terminal): tc <= 1.
  - reload_mode = 0: q <= 0, state <= IDLE.
  - reload_mode = 1: q <= reload, stay RUN (q never shows 0; period = reload cycles of en).
- RUN, en = 0: q held, tc <= 0.
- IDLE: q held, tc <= 0; en ignored; no underflow or wrap from 0.
- reload_mode is sampled only at the terminal edge; changing it mid-count is legal.
- Counter bits are JK cells: count mode J=K=1 for bit i when all lower bits are 0 (borrow chain), else J=K=0; load/reload mode J=value bit, K=~value bit.

## Timing
- Load latency: q shows din after the first rising edge with load = 1.
- Decrement: one per edge with en = 1 in RUN; zero added latency.
- tc rises on the same edge q reaches 0 (one-shot) or reloads; high for exactly one cycle, even if en stays high.
- busy falls on the same edge as one-shot tc.
- From load of N with en held high: tc asserted on edge N after the load edge.
- Asynchronous reset acts immediately on all outputs, independent of clk.

## Structure
- Package jk_ctr_pkg: state enum (IDLE, RUN); JK input encodings JK_HOLD = 2'b00, JK_RESET = 2'b01, JK_SET = 2'b10, JK_TOGGLE = 2'b11.
- Sub-module jk_ff_rn: single JK flip-flop, clk, asynchronous active-low rst_n clearing q to 0, case on {j,k} with default to hold. jk_down_ctr instantiates WIDTH of these via generate, plus state, tc and reload registers and the J/K steering logic.

## Test plan
- Reset: assert rst_n = 0 mid-cycle -> q = 0, tc = 0, busy = 0 immediately, without a clock edge.
- One-shot: load din = 5, reload_mode = 0, en high -> q = 5,4,3,2,1,0; tc high only on the edge q becomes 0; busy drops with it; q stays 0 afterwards.
- Auto-reload: load 3, reload_mode = 1, en high -> q = 3,2,1,3,2,1,3; tc pulses every 3rd cycle; busy stays 1.
- Enable gating: load 4, toggle en 1,0,0,1 -> q = 4,3,3,3,2; tc stays 0.
- Boundaries: load 0 -> IDLE, no tc; load 9 while q = 2 in RUN -> q = 9, no tc; load coincident with terminal edge -> load wins, tc = 0.
- WIDTH = 8: load 0xFF, one-shot, en high -> tc after exactly 255 edges, q = 0x00, no wrap to 0xFF.
